// File: rtl/hpm_counter_bank_pkg.sv
// CSR addresses, counter/event indices and mhpmevent layout shared by the
// machine performance-counter bank.
package hpm_counter_bank_pkg;

  localparam logic [11:0] MCOUNTINHIBIT       = 12'h320;
  localparam logic [11:0] MHPMEVENT_BASE      = 12'h320;
  localparam logic [11:0] MHPMEVENTH_BASE     = 12'h720;
  localparam logic [11:0] MCYCLE              = 12'hB00;
  localparam logic [11:0] MINSTRET            = 12'hB02;
  localparam logic [11:0] MHPMCOUNTER_BASE    = 12'hB00;
  localparam logic [11:0] MHPMCOUNTERH_OFFSET = 12'h080;

  localparam int IDX_CYCLE     = 0;
  localparam int IDX_TIME      = 1;
  localparam int IDX_INSTRET   = 2;
  localparam int IDX_HPM_FIRST = 3;
  localparam int EV_NEVER      = 0;

  // Selector storage is sized for up to 32 events; writes mask to the
  // width actually implemented by the bank instance.
  localparam int EVSEL_MAX = 5;

  typedef struct packed {
    logic                 of;
    logic [EVSEL_MAX-1:0] sel;
  } mhpmevent_t;

  function automatic logic in_blk(logic [11:0] adr, logic [11:0] base);
    return (adr & 12'hFE0) == base;
  endfunction

  function automatic logic in_bank(logic [11:0] adr);
    return (adr >= 12'h320 && adr <= 12'h33F) ||
           (adr >= 12'h723 && adr <= 12'h73F) ||
           (adr >= 12'hB00 && adr <= 12'hB9F);
  endfunction

endpackage

// File: rtl/hpm_counter_bank_hpmcounter.sv
// One 64-bit performance counter: independent low/high half writes that
// take priority over the increment, and a wrap flag for overflow tracking.
module hpm_counter_bank_hpmcounter (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        inc,
  input  logic [63:0] wdata,
  output logic [63:0] count,
  output logic        wrap
);

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata[31:0];
      if (wr_hi) count[63:32] <= wdata[63:32];
    end else if (inc) count <= count + 64'd1;
  end

  assign wrap = inc && !(wr_lo || wr_hi) && (&count);

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine performance-counter bank: mcycle, minstret and programmable
// mhpmcounters with inhibit and RV32 high-half access. Define HPM_OVERFLOW_EN
// to add per-counter overflow bits and the overflow interrupt.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NUM_COUNTERS = 32,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InstrValidNotFlushedW,
  input  logic [NUM_EVENTS-1:0] EventsW,
  input  logic                  CSRMWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  output logic [XLEN-1:0]       CSRReadValM,
  output logic                  IllegalCSRAccessM,
  output logic                  HPMOverflowIrq
);

  localparam int NC         = NUM_COUNTERS;
  localparam int IW         = $clog2(NC);
  localparam int EVSEL_BITS = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int EVPAD      = 2 ** EVSEL_MAX;
  localparam bit RV32       = (XLEN == 32);
  localparam logic [NC-1:0] INH_MASK = ~(NC'(1) << IDX_TIME);

  logic [63:0]          wd, rdata;
  logic [EVPAD-1:0]     ev_pad;
  logic [4:0]           idx;
  logic [IW-1:0]        ix;
  logic                 impl_idx, hpm_idx, inh_wr, unused_ok;
  logic                 sel_inh, sel_ev, sel_evh, sel_cnt, sel_cnth;
  logic [NC-1:0]        inhibit, wrap, fire;
  logic [NC-1:0][63:0]  count;
  mhpmevent_t [NC-1:0]  ev_rd;
`ifdef HPM_OVERFLOW_EN
  logic [NC-1:0]        of_vec;
  logic                 irq_q;
`endif

  // RV32 replicates the write word so either half of a counter can take it.
  if (RV32) begin : g_wd32
    assign wd = {CSRWriteValM, CSRWriteValM};
  end else begin : g_wd64
    assign wd = CSRWriteValM;
  end

  assign ev_pad   = EVPAD'(EventsW);
  assign idx      = CSRAdrM[4:0];
  assign ix       = IW'(idx);
  assign impl_idx = (idx != 5'(IDX_TIME)) && (int'(idx) < NC);
  assign hpm_idx  = (int'(idx) >= IDX_HPM_FIRST) && (int'(idx) < NC);

  always_comb begin
    sel_inh  = 1'b0;
    sel_ev   = 1'b0;
    sel_evh  = 1'b0;
    sel_cnt  = 1'b0;
    sel_cnth = 1'b0;
    rdata    = '0;
    if (CSRAdrM == MCOUNTINHIBIT) begin
      sel_inh = 1'b1;
      rdata   = 64'(inhibit);
    end else if (in_blk(CSRAdrM, MHPMEVENT_BASE) && hpm_idx) begin
      sel_ev = 1'b1;
      rdata  = RV32 ? 64'(ev_rd[ix].sel) : {ev_rd[ix].of, 63'(ev_rd[ix].sel)};
    end else if (RV32 && in_blk(CSRAdrM, MHPMEVENTH_BASE) && hpm_idx) begin
      sel_evh = 1'b1;
      rdata   = {32'b0, ev_rd[ix].of, 31'b0};
    end else if (in_blk(CSRAdrM, MHPMCOUNTER_BASE) && impl_idx) begin
      sel_cnt = 1'b1;
      rdata   = RV32 ? {32'b0, count[ix][31:0]} : count[ix];
    end else if (RV32 && in_blk(CSRAdrM, MHPMCOUNTER_BASE + MHPMCOUNTERH_OFFSET) && impl_idx) begin
      sel_cnth = 1'b1;
      rdata    = {32'b0, count[ix][63:32]};
    end
  end

  assign CSRReadValM       = rdata[XLEN-1:0];
  assign IllegalCSRAccessM = in_bank(CSRAdrM) && !(sel_inh || sel_ev || sel_evh || sel_cnt || sel_cnth);
  assign inh_wr            = CSRMWriteM && sel_inh;

  always_ff @(posedge clk) begin
    if (reset) inhibit <= '0;
    else if (inh_wr) inhibit <= wd[NC-1:0] & INH_MASK;
  end

  for (genvar i = 0; i < NC; i++) begin : g_ctr
    if (i < IDX_HPM_FIRST) begin : g_fixed
      assign ev_rd[i] = '0;
      assign fire[i]  = (i == IDX_INSTRET) ? InstrValidNotFlushedW : (i == IDX_CYCLE);
`ifdef HPM_OVERFLOW_EN
      assign of_vec[i] = 1'b0;
`endif
    end else begin : g_hpm
      mhpmevent_t ev;
      logic       hit, of_nxt;
      assign hit = (idx == 5'(i));
      always_ff @(posedge clk) begin
        if (reset) ev <= '0;
        else begin
          if (CSRMWriteM && sel_ev && hit) ev.sel <= EVSEL_MAX'(wd[EVSEL_BITS-1:0]);
          ev.of <= of_nxt;
        end
      end
`ifdef HPM_OVERFLOW_EN
      // A wrap wins over a same-cycle software write so no overflow is lost.
      assign of_nxt    = wrap[i] ? 1'b1 :
                         (CSRMWriteM && hit && (RV32 ? sel_evh : sel_ev)) ? wd[63] : ev.of;
      assign of_vec[i] = of_nxt;
`else
      assign of_nxt = 1'b0;
`endif
      assign fire[i]  = (ev.sel != 5'(EV_NEVER)) && ev_pad[ev.sel];
      assign ev_rd[i] = ev;
    end

    if (i == IDX_TIME) begin : g_time
      assign count[i] = '0;
      assign wrap[i]  = 1'b0;
    end else begin : g_cnt
      logic hit, inh;
      assign hit = (idx == 5'(i));
      // An inhibit write applies to the increment on its own edge.
      assign inh = inh_wr ? wd[i] : inhibit[i];
      hpm_counter_bank_hpmcounter u_ctr (
        .clk   (clk),
        .reset (reset),
        .wr_lo (CSRMWriteM && hit && sel_cnt),
        .wr_hi (CSRMWriteM && hit && (sel_cnth || (sel_cnt && !RV32))),
        .inc   (fire[i] && !inh),
        .wdata (wd),
        .count (count[i]),
        .wrap  (wrap[i])
      );
    end
  end

`ifdef HPM_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= |of_vec;
  end
  assign HPMOverflowIrq = irq_q;
  assign unused_ok      = ^{fire[IDX_TIME], wrap[IDX_HPM_FIRST-1:0]};
`else
  assign HPMOverflowIrq = 1'b0;
  assign unused_ok      = ^{fire[IDX_TIME], wrap};
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: an RV64 and an RV32 instance share
// clock, reset and event inputs; read expectations are queued then compared.
module tb_hpm_counter_bank;

`ifdef HPM_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr = 1'b0;
  logic [15:0] events = '0;

  logic        we64 = 1'b0, ill64, irq64;
  logic [11:0] adr64 = '0;
  logic [63:0] wv64 = '0, r64;
  logic        we32 = 1'b0, ill32, irq32;
  logic [11:0] adr32 = '0;
  logic [31:0] wv32 = '0, r32;

  int n_tests = 0;
  int n_fail  = 0;
  logic [64:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hpm_counter_bank #(.XLEN(64), .NUM_COUNTERS(32), .NUM_EVENTS(16)) d64 (
    .clk(clk), .reset(reset), .InstrValidNotFlushedW(instr), .EventsW(events),
    .CSRMWriteM(we64), .CSRAdrM(adr64), .CSRWriteValM(wv64),
    .CSRReadValM(r64), .IllegalCSRAccessM(ill64), .HPMOverflowIrq(irq64));

  hpm_counter_bank #(.XLEN(32), .NUM_COUNTERS(8), .NUM_EVENTS(16)) d32 (
    .clk(clk), .reset(reset), .InstrValidNotFlushedW(instr), .EventsW(events),
    .CSRMWriteM(we32), .CSRAdrM(adr32), .CSRWriteValM(wv32),
    .CSRReadValM(r32), .IllegalCSRAccessM(ill32), .HPMOverflowIrq(irq32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input logic [64:0] got);
    logic [64:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, got[63:0], e[63:0]);
    chk({t, "_ill"}, 64'(got[64]), 64'(e[64]));
  endtask

  task automatic rd_64(input logic [11:0] a, input logic [63:0] v, input logic ill, input string tag);
    exp_q.push_back({ill, v});
    tag_q.push_back(tag);
    adr64 = a;
    #1;
    pop_cmp({ill64, r64});
  endtask

  task automatic rd_32(input logic [11:0] a, input logic [31:0] v, input logic ill, input string tag);
    exp_q.push_back({ill, 32'b0, v});
    tag_q.push_back(tag);
    adr32 = a;
    #1;
    pop_cmp({ill32, 32'b0, r32});
  endtask

  task automatic wr_64(input logic [11:0] a, input logic [63:0] v);
    adr64 = a; wv64 = v; we64 = 1'b1;
    @(negedge clk);
    we64 = 1'b0;
  endtask

  task automatic wr_32(input logic [11:0] a, input logic [31:0] v);
    adr32 = a; wv32 = v; we32 = 1'b1;
    @(negedge clk);
    we32 = 1'b0;
  endtask

  task automatic pulse(input int e);
    events = 16'(1) << e;
    @(negedge clk);
    events = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rd_64(12'hB00, 64'd0, 1'b0, "rst_mcycle");
    rd_64(12'h320, 64'd0, 1'b0, "rst_inhibit");
    rd_32(12'hB00, 32'd0, 1'b0, "rst_mcycle32");
    chk("rst_irq", 64'(irq64), 64'd0);
    reset = 1'b0;

    repeat (100) @(negedge clk);
    rd_64(12'hB00, 64'd100, 1'b0, "mcycle_100");
    rd_64(12'hB02, 64'd0, 1'b0, "minstret_idle");
    rd_32(12'hB00, 32'd100, 1'b0, "mcycle32_100");

    instr = 1'b1;
    repeat (3) @(negedge clk);
    instr = 1'b0;
    rd_64(12'hB02, 64'd3, 1'b0, "minstret_3");

    wr_64(12'h323, 64'd5);
    rd_64(12'h323, 64'd5, 1'b0, "evsel3");
    for (int k = 0; k < 7; k++) pulse(5);
    rd_64(12'hB03, 64'd7, 1'b0, "hpm3_7");
    for (int k = 0; k < 3; k++) pulse(4);
    rd_64(12'hB03, 64'd7, 1'b0, "hpm3_other_ev");
    rd_32(12'hB03, 32'd0, 1'b0, "hpm3_32_unsel");

    wr_64(12'h324, 64'h0000_0000_0000_FFF4);
    rd_64(12'h324, 64'd4, 1'b0, "evsel_mask");
    pulse(4); pulse(4);
    rd_64(12'hB04, 64'd2, 1'b0, "hpm4_2");

    adr64 = 12'hB03; wv64 = 64'h10; we64 = 1'b1; events = 16'h0020;
    @(negedge clk);
    we64 = 1'b0; events = '0;
    rd_64(12'hB03, 64'h10, 1'b0, "wr_beats_ev");
    @(negedge clk);
    rd_64(12'hB03, 64'h10, 1'b0, "wr_beats_ev_hold");

    wr_64(12'hB00, '1);
    rd_64(12'hB00, '1, 1'b0, "mcycle_ones");
    @(negedge clk);
    rd_64(12'hB00, 64'd0, 1'b0, "mcycle_wrap");

    wr_64(12'hB00, 64'h50);
    wr_64(12'h320, 64'h1);
    rd_64(12'hB00, 64'h50, 1'b0, "inh_same_edge");
    repeat (5) @(negedge clk);
    rd_64(12'hB00, 64'h50, 1'b0, "inh_frozen");
    rd_64(12'h320, 64'h1, 1'b0, "inh_read");
    wr_64(12'h320, '1);
    rd_64(12'h320, 64'hFFFF_FFFD, 1'b0, "inh_bit1_zero");
    instr = 1'b1;
    @(negedge clk);
    instr = 1'b0;
    rd_64(12'hB02, 64'd3, 1'b0, "minstret_inh");
    wr_64(12'h320, 64'h0);
    rd_64(12'hB00, 64'h51, 1'b0, "uninh_same_edge");

    rd_64(12'hB01, 64'd0, 1'b1, "ill_time");
    rd_64(12'h321, 64'd0, 1'b1, "ill_321");
    rd_64(12'hB83, 64'd0, 1'b1, "ill_hi_rv64");
    rd_64(12'h723, 64'd0, 1'b1, "ill_evh_rv64");
    rd_64(12'hB20, 64'd0, 1'b1, "ill_b20");
    rd_64(12'h300, 64'd0, 1'b0, "outside_300");
    rd_64(12'h720, 64'd0, 1'b0, "outside_720");
    rd_32(12'hB08, 32'd0, 1'b1, "ill32_unimpl");
    rd_32(12'hB81, 32'd0, 1'b1, "ill32_timeh");

    wr_32(12'h323, 32'd5);
    wr_32(12'hB03, 32'hFFFF_FFFF);
    wr_32(12'hB83, 32'd0);
    rd_32(12'hB03, 32'hFFFF_FFFF, 1'b0, "rv32_lo_pre");
    rd_32(12'hB83, 32'd0, 1'b0, "rv32_hi_pre");
    pulse(5);
    rd_32(12'hB03, 32'd0, 1'b0, "rv32_lo_carry");
    rd_32(12'hB83, 32'd1, 1'b0, "rv32_hi_carry");
    wr_32(12'hB03, 32'd7);
    rd_32(12'hB03, 32'd7, 1'b0, "rv32_lo_wr");
    rd_32(12'hB83, 32'd1, 1'b0, "rv32_hi_kept");

    wr_64(12'h323, 64'd5);
    wr_64(12'hB03, '1);
    pulse(5);
    rd_64(12'hB03, 64'd0, 1'b0, "hpm3_wrap");
    chk("of_irq_set", 64'(irq64), 64'(OVF));
    rd_64(12'h323, OVF ? 64'h8000_0000_0000_0005 : 64'd5, 1'b0, "of3_read");
    wr_64(12'h323, 64'd5);
    chk("of_irq_clr", 64'(irq64), 64'd0);
    wr_64(12'h323, 64'h8000_0000_0000_0005);
    chk("of_sw_set", 64'(irq64), 64'(OVF));
    wr_64(12'h323, 64'd5);
    rd_64(12'h323, 64'd5, 1'b0, "of3_cleared");

    instr = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    rd_64(12'hB00, 64'd0, 1'b0, "midrst_mcycle");
    rd_64(12'h323, 64'd0, 1'b0, "midrst_evsel");
    rd_32(12'hB83, 32'd0, 1'b0, "midrst_hi32");
    chk("midrst_irq", 64'(irq64), 64'd0);
    reset = 1'b0;
    instr = 1'b0;
    @(negedge clk);
    rd_64(12'hB00, 64'd1, 1'b0, "postrst_mcycle");
    rd_64(12'hB02, 64'd0, 1'b0, "postrst_minstret");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
